// File: rtl/mux41_scan_ctrl_pkg.sv
// Shared types and helpers for the mux41 scan controller:
// state codes, channel indices and the one-hot select decode.
package mux41_scan_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/mux41_scan_ctrl_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps on its own,
// and flags the last cycle of each dwell.
module mux41_scan_ctrl_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == LAST);

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux41_scan_ctrl.sv
// Scan controller for a 4:1 mux: walks one-hot selects A..D with a fixed
// dwell, samples Y at the end of each dwell and publishes a 4-bit frame.
module mux41_scan_ctrl
  import mux41_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CONT,
  input  logic       ABORT,
  input  logic       Y,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic [3:0] SAMPLE,
  output logic       VALID,
  output logic       BUSY
);

  state_t     state, state_next;
  logic [1:0] idx;
  logic [3:0] sel;
  logic [3:0] shadow;
  logic       tc;
  logic       start_ok;
  logic       frame_end;

  mux41_scan_ctrl_dwell_cnt #(
    .DWELL(DWELL),
    .CW   (CW)
  ) u_dwell_cnt (
    .clk(CLK),
    .rst(RST),
    .clr(state_next == ST_IDLE),
    .en (state == ST_SCAN),
    .tc (tc)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    frame_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START && !ABORT) begin
          start_ok   = 1'b1;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        frame_end = tc && (idx == CH_D);
        // An abort on the frame-end cycle still lets the frame publish below.
        if (ABORT || (frame_end && !CONT)) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx    <= CH_A;
      sel    <= '0;
      shadow <= '0;
      SAMPLE <= '0;
      VALID  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (start_ok) begin
        idx    <= CH_A;
        sel    <= ch_onehot(CH_A);
        shadow <= '0;
      end else if (state == ST_SCAN) begin
        if (tc) begin
          shadow[idx] <= Y;
          idx         <= idx + 2'd1;
        end
        if (frame_end) begin
          SAMPLE <= {Y, shadow[2:0]};
          VALID  <= 1'b1;
        end
        // Selects come from a register so the one-hot code never glitches.
        if (state_next == ST_IDLE) begin
          sel    <= '0;
          idx    <= CH_A;
          shadow <= '0;
        end else if (tc) begin
          sel <= ch_onehot(idx + 2'd1);
        end
      end
    end
  end

  assign {S3, S2, S1, S0} = sel;
  assign BUSY             = (state == ST_SCAN);

endmodule
